// File: rtl/mul_div_if.sv
// Operand, request and result bundle for mul_div_unit.
// The requester (master) drives operands and Start; the unit (slave) returns status and HI/LO.
interface mul_div_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  MDFun;
  logic        Sign;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDFun, Sign, Start,
                  input  Busy, Done, HI, LO);
  modport slave  (input  A, B, MDFun, Sign, Start,
                  output Busy, Done, HI, LO);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// It processes one bit per cycle: shift-add multiply and restoring divide, both on magnitudes.
module mul_div_unit (
  input  logic      clk,
  input  logic      reset,
  mul_div_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] FN_MULT = 2'b00;
  localparam logic [1:0] FN_DIV  = 2'b01;
  localparam logic [1:0] FN_MTHI = 2'b10;
  localparam logic [1:0] FN_MTLO = 2'b11;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_a_q;
  logic        neg_b_q;
  logic        b_zero_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        a_neg_d;
  logic        b_neg_d;
  logic [31:0] a_mag_d;
  logic [31:0] b_mag_d;
  logic [32:0] mul_sum_d;
  logic [32:0] div_shift_d;
  logic        div_ge_d;
  logic [32:0] div_rem_d;
  logic [63:0] acc_d;
  logic [63:0] prod_fix_d;
  logic [31:0] quo_fix_d;
  logic [31:0] rem_fix_d;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  always_comb begin
    a_neg_d = bus.Sign & bus.A[31];
    b_neg_d = bus.Sign & bus.B[31];
    a_mag_d = a_neg_d ? (32'd0 - bus.A) : bus.A;
    b_mag_d = b_neg_d ? (32'd0 - bus.B) : bus.B;
  end

  // acc_q holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum_d   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift_d = {acc_q[63:32], acc_q[31]};
    div_ge_d    = div_shift_d >= {1'b0, opnd_q};
    div_rem_d   = div_ge_d ? (div_shift_d - {1'b0, opnd_q}) : div_shift_d;
    acc_d       = is_div_q ? {div_rem_d[31:0], acc_q[30:0], div_ge_d}
                           : {mul_sum_d, acc_q[31:1]};
  end

  always_comb begin
    prod_fix_d = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_d) : acc_d;
    quo_fix_d  = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_d[31:0]) : acc_d[31:0];
    rem_fix_d  = neg_a_q ? (32'd0 - acc_d[63:32]) : acc_d[63:32];
    // Divide by zero leaves |A| as remainder, so only the quotient needs forcing.
    if (b_zero_q) begin
      quo_fix_d = 32'hFFFF_FFFF;
    end
    hi_d = is_div_q ? rem_fix_d : prod_fix_d[63:32];
    lo_d = is_div_q ? quo_fix_d : prod_fix_d[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (bus.Start) begin
            unique case (bus.MDFun)
              FN_MULT, FN_DIV: begin
                state_q  <= RUN;
                busy_q   <= 1'b1;
                cnt_q    <= 5'd0;
                is_div_q <= (bus.MDFun == FN_DIV);
                neg_a_q  <= a_neg_d;
                neg_b_q  <= b_neg_d;
                b_zero_q <= (bus.MDFun == FN_DIV) && (bus.B == 32'd0);
                opnd_q   <= (bus.MDFun == FN_DIV) ? b_mag_d : a_mag_d;
                acc_q    <= {32'd0, (bus.MDFun == FN_DIV) ? a_mag_d : b_mag_d};
              end
              FN_MTHI: hi_q <= bus.A;
              FN_MTLO: lo_q <= bus.A;
            endcase
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: inputs driven and outputs sampled on the falling edge.
module tb_mul_div_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   nbusy;
  int   ndone;

  mul_div_if mdif ();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a request for one cycle, then scramble the operands so late changes are exercised.
  task automatic start_op(input logic [1:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mdif.MDFun = f; mdif.Sign = s; mdif.A = a; mdif.B = b; mdif.Start = 1'b1;
    @(negedge clk);
    mdif.Start = 1'b0; mdif.A = ~a; mdif.B = b ^ 32'h5A5A_5A5A; mdif.Sign = ~s; mdif.MDFun = 2'b10;
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (mdif.Done === 1'b1) break;
      if (mdif.Busy === 1'b1) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] f, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int nb;
    start_op(f, s, a, b);
    wait_done(nb);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    check({tag, "_done"}, 64'(mdif.Done), 64'd1);
    check({tag, "_hi"}, 64'(mdif.HI), 64'(ehi));
    check({tag, "_lo"}, 64'(mdif.LO), 64'(elo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'({mdif.Done, mdif.Busy}), 64'd0);
    check({tag, "_hold"}, {mdif.HI, mdif.LO}, {ehi, elo});
  endtask

  initial begin
    checks = 0; errors = 0;
    mdif.A = '0; mdif.B = '0; mdif.MDFun = '0; mdif.Sign = 1'b0; mdif.Start = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_state", {30'd0, mdif.Busy, mdif.Done, mdif.HI}, 64'd0);
    check("reset_lo", 64'(mdif.LO), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult_u", 2'b00, 1'b0, 32'h0000_E129, 32'hFFFF_1EDF, 32'h0000_E128, 32'h39FD_F0B7);
    run_op("mult_s", 2'b00, 1'b1, 32'h0000_E129, 32'hFFFF_1EDF, 32'hFFFF_FFFF, 32'h39FD_F0B7);
    run_op("div_s_neg", 2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_s_negb", 2'b01, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_u", 2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_min", 2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div0_u", 2'b01, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div0_s", 2'b01, 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    run_op("mult_umax", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_smin", 2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // MTLO / MTHI: one-edge writes, no Busy or Done.
    @(negedge clk);
    mdif.MDFun = 2'b11; mdif.A = 32'hDEAD_BEEF; mdif.Start = 1'b1;
    @(negedge clk);
    mdif.Start = 1'b0;
    check("mtlo_regs", {mdif.HI, mdif.LO}, {32'h4000_0000, 32'hDEAD_BEEF});
    check("mtlo_flags", 64'({mdif.Busy, mdif.Done}), 64'd0);
    @(negedge clk);
    check("mtlo_flags_after", 64'({mdif.Busy, mdif.Done}), 64'd0);
    mdif.MDFun = 2'b10; mdif.A = 32'h1357_9BDF; mdif.Start = 1'b1;
    @(negedge clk);
    mdif.Start = 1'b0;
    check("mthi_regs", {mdif.HI, mdif.LO}, {32'h1357_9BDF, 32'hDEAD_BEEF});
    check("mthi_flags", 64'({mdif.Busy, mdif.Done}), 64'd0);

    // Busy lockout: DIV and MTHI requests during a MULT are dropped.
    start_op(2'b00, 1'b0, 32'd3, 32'd5);
    check("lock_busy", 64'(mdif.Busy), 64'd1);
    repeat (3) @(negedge clk);
    mdif.MDFun = 2'b01; mdif.A = 32'd100; mdif.B = 32'd7; mdif.Start = 1'b1;
    @(negedge clk);
    mdif.MDFun = 2'b10; mdif.A = 32'hAAAA_AAAA;
    @(negedge clk);
    mdif.Start = 1'b0;
    check("lock_hi_untouched", 64'(mdif.HI), 64'h1357_9BDF);
    check("lock_still_busy", 64'(mdif.Busy), 64'd1);
    wait_done(nbusy);
    check("lock_done", 64'(mdif.Done), 64'd1);
    check("lock_result", {mdif.HI, mdif.LO}, {32'd0, 32'd15});
    // Back-to-back request in the DONE cycle.
    mdif.MDFun = 2'b00; mdif.Sign = 1'b0; mdif.A = 32'd7; mdif.B = 32'd6; mdif.Start = 1'b1;
    @(negedge clk);
    mdif.Start = 1'b0; mdif.A = 32'd0;
    check("b2b_accept", 64'({mdif.Busy, mdif.Done}), 64'b10);
    wait_done(nbusy);
    check("b2b_busy_cycles", 64'(nbusy), 64'd32);
    check("b2b_result", {mdif.HI, mdif.LO}, {32'd0, 32'd42});
    @(negedge clk);
    check("b2b_single_done", 64'(mdif.Done), 64'd0);

    // Asynchronous reset in the middle of a MULT.
    start_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_flags", 64'({mdif.Busy, mdif.Done}), 64'd0);
    check("async_rst_regs", {mdif.HI, mdif.LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mdif.Done === 1'b1 || mdif.Busy === 1'b1) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    // Start honoured at the first edge after reset release.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mdif.MDFun = 2'b00; mdif.Sign = 1'b1; mdif.A = 32'hFFFF_FFFA; mdif.B = 32'd7; mdif.Start = 1'b1;
    @(negedge clk);
    mdif.Start = 1'b0;
    check("first_start_busy", 64'(mdif.Busy), 64'd1);
    wait_done(nbusy);
    check("first_start_busy_cycles", 64'(nbusy), 64'd32);
    check("first_start_result", {mdif.HI, mdif.LO}, 64'hFFFF_FFFF_FFFF_FFD6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
